// File: rtl/tl45_pkg.sv
// Shared types and field positions for the TL45 decode stage.
package tl45_pkg;

  localparam int unsigned NumOpcodesDefault = 13;

  // Instruction field positions
  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 27;
  localparam int unsigned RiBit  = 26;
  localparam int unsigned HiBit  = 25;
  localparam int unsigned ZxBit  = 24;
  localparam int unsigned DrMsb  = 23;
  localparam int unsigned DrLsb  = 20;
  localparam int unsigned Sr1Msb = 19;
  localparam int unsigned Sr1Lsb = 16;
  localparam int unsigned Sr2Msb = 15;
  localparam int unsigned Sr2Lsb = 12;
  localparam int unsigned ImmMsb = 15;

  typedef enum logic [4:0] {
    OpNop  = 5'd0,
    OpAdd  = 5'd1,
    OpSub  = 5'd2,
    OpMul  = 5'd3,
    OpOr   = 5'd4,
    OpXor  = 5'd5,
    OpAnd  = 5'd6,
    OpShl  = 5'd7,
    OpShr  = 5'd8,
    OpLw   = 5'd9,
    OpSw   = 5'd10,
    OpJmp  = 5'd11,
    OpCall = 5'd12
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] imm32;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/tl45_decode_logic.sv
// Combinational field extraction for one {pc, instruction} pair.
module tl45_decode_logic
  import tl45_pkg::*;
#(
  parameter int unsigned NUM_OPCODES = NumOpcodesDefault
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output decoded_t    dec_o
);

  logic        ri;
  logic [15:0] imm16;
  logic [4:0]  opcode;

  assign ri     = inst_i[RiBit];
  assign imm16  = inst_i[ImmMsb:0];
  assign opcode = inst_i[OpMsb:OpLsb];

  always_comb begin
    dec_o           = '0;
    dec_o.pc        = pc_i;
    dec_o.opcode    = opcode;
    dec_o.dr        = inst_i[DrMsb:DrLsb];
    dec_o.sr1       = inst_i[Sr1Msb:Sr1Lsb];
    dec_o.sr2       = ri ? 4'h0 : inst_i[Sr2Msb:Sr2Lsb];
    dec_o.use_imm   = ri;
    dec_o.is_load   = (opcode == OpLw);
    dec_o.is_store  = (opcode == OpSw);
    dec_o.is_branch = (opcode == OpJmp) || (opcode == OpCall);
    dec_o.illegal   = ({27'd0, opcode} >= NUM_OPCODES);
    // hi wins over zx; neither means sign-extend
    if (!ri) begin
      dec_o.imm32 = 32'h0;
    end else if (inst_i[HiBit]) begin
      dec_o.imm32 = {imm16, 16'h0};
    end else if (inst_i[ZxBit]) begin
      dec_o.imm32 = {16'h0, imm16};
    end else begin
      dec_o.imm32 = {{16{imm16[15]}}, imm16};
    end
  end

endmodule

// File: rtl/tl45_decode.sv
// Decode stage: output pipeline register plus a one-entry skid slot so the
// stall back to prefetch is registered.
module tl45_decode
  import tl45_pkg::*;
#(
  parameter int unsigned NUM_OPCODES = NumOpcodesDefault
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic        o_pipe_stall,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_sr1,
  output logic [3:0]  o_sr2,
  output logic [31:0] o_imm32,
  output logic        o_use_imm,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_is_branch,
  output logic        o_illegal
);

  decoded_t dec;
  decoded_t out_d, out_q;
  decoded_t skid_d, skid_q;
  logic     valid_d, valid_q;
  logic     skid_full_d, skid_full_q;
  logic     accept;
  logic     advance;

  tl45_decode_logic #(
    .NUM_OPCODES(NUM_OPCODES)
  ) u_decode_logic (
    .pc_i  (i_buf_pc),
    .inst_i(i_buf_inst),
    .dec_o (dec)
  );

  assign accept  = (i_buf_inst != 32'h0) && !skid_full_q && !i_flush;
  assign advance = !valid_q || !i_stall;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    valid_d     = valid_q;
    skid_full_d = skid_full_q;
    if (i_flush) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (advance) begin
      // A full skid implies the stall was up, so no accept can coincide.
      if (skid_full_q) begin
        out_d       = skid_q;
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d   = dec;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = dec;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      valid_q     <= valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign o_pipe_stall = skid_full_q;
  assign o_valid      = valid_q;
  assign o_pc         = out_q.pc;
  assign o_opcode     = out_q.opcode;
  assign o_dr         = out_q.dr;
  assign o_sr1        = out_q.sr1;
  assign o_sr2        = out_q.sr2;
  assign o_imm32      = out_q.imm32;
  assign o_use_imm    = out_q.use_imm;
  assign o_is_load    = out_q.is_load;
  assign o_is_store   = out_q.is_store;
  assign o_is_branch  = out_q.is_branch;
  assign o_illegal    = out_q.illegal;

endmodule

// File: tb/tb_tl45_decode.sv
// Bench for tl45_decode: a two-deep FIFO model checked every cycle, plus
// hand-computed literal expectations along a directed stimulus sequence.
module tb_tl45_decode;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_buf_pc;
  logic [31:0] i_buf_inst;
  logic        o_pipe_stall;
  logic        i_stall;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr;
  logic [3:0]  o_sr1;
  logic [3:0]  o_sr2;
  logic [31:0] o_imm32;
  logic        o_use_imm;
  logic        o_is_load;
  logic        o_is_store;
  logic        o_is_branch;
  logic        o_illegal;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  tl45_decode dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_buf_pc    (i_buf_pc),
    .i_buf_inst  (i_buf_inst),
    .o_pipe_stall(o_pipe_stall),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_pc        (o_pc),
    .o_opcode    (o_opcode),
    .o_dr        (o_dr),
    .o_sr1       (o_sr1),
    .o_sr2       (o_sr2),
    .o_imm32     (o_imm32),
    .o_use_imm   (o_use_imm),
    .o_is_load   (o_is_load),
    .o_is_store  (o_is_store),
    .o_is_branch (o_is_branch),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] imm;
    logic [4:0]  flags;  // {use_imm, load, store, branch, illegal}
  } exp_t;

  exp_t q[$];
  bit   zero_out = 1'b0;

  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] inst);
    exp_t        e;
    int unsigned op;
    int unsigned imm16;
    bit          ri;
    op     = inst / 32'h0800_0000;
    imm16  = inst % 32'h1_0000;
    ri     = inst[26];
    e.pc   = pc;
    e.op   = op[4:0];
    e.dr   = 4'((inst / 32'h10_0000) % 16);
    e.sr1  = 4'((inst / 32'h1_0000) % 16);
    e.sr2  = ri ? 4'h0 : 4'((inst / 32'h1000) % 16);
    if (!ri)           e.imm = 32'h0;
    else if (inst[25]) e.imm = imm16 * 32'h1_0000;
    else if (inst[24]) e.imm = imm16;
    else if (imm16 >= 32768) e.imm = imm16 - 32'h1_0000;
    else               e.imm = imm16;
    e.flags = {ri, op == 9, op == 10, (op == 11) || (op == 12), op >= 13};
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: output register + skid slot behave as a two-entry queue.
  always @(posedge i_clk) begin
    bit acc;
    acc = (i_buf_inst != 32'h0) && (q.size() < 2) && !i_flush;
    if (!i_reset_n) begin
      q.delete();
      zero_out = 1'b1;
    end else if (i_flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !i_stall) void'(q.pop_front());
      if (acc) begin
        q.push_back(model_decode(i_buf_pc, i_buf_inst));
        zero_out = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (started) begin
      check("valid", 64'(o_valid), 64'(q.size() > 0));
      check("pipe_stall", 64'(o_pipe_stall), 64'(q.size() == 2));
      if (q.size() > 0) begin
        check("pc", 64'(o_pc), 64'(q[0].pc));
        check("fields", {o_opcode, o_dr, o_sr1, o_sr2}, {q[0].op, q[0].dr, q[0].sr1, q[0].sr2});
        check("imm32", 64'(o_imm32), 64'(q[0].imm));
        check("flags", 64'({o_use_imm, o_is_load, o_is_store, o_is_branch, o_illegal}),
              64'(q[0].flags));
      end
      if (zero_out) begin
        check("reset_data", {o_pc, o_imm32}, 64'h0);
        check("reset_ctl", {o_opcode, o_dr, o_sr1, o_sr2, o_use_imm, o_is_load, o_is_store,
                            o_is_branch, o_illegal}, 64'h0);
      end
    end
  end

  task automatic step(input logic [31:0] pc, input logic [31:0] inst, input logic st,
                      input logic fl, input logic rn);
    i_buf_pc   = pc;
    i_buf_inst = inst;
    i_stall    = st;
    i_flush    = fl;
    i_reset_n  = rn;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_buf_pc   = '0;
    i_buf_inst = '0;
    i_stall    = 1'b0;
    i_flush    = 1'b0;
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    started = 1'b1;
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("lit_reset", {o_valid, o_pipe_stall, o_pc}, 64'h0);

    // ADD r1,r2,r3
    step(32'h100, 32'h0812_3000, 1'b0, 1'b0, 1'b1);
    check("lit_add_valid", 64'(o_valid), 64'h1);
    check("lit_add_pc", 64'(o_pc), 64'h100);
    check("lit_add_fields", {o_opcode, o_dr, o_sr1, o_sr2}, {5'd1, 4'd1, 4'd2, 4'd3});
    check("lit_add_imm", {o_imm32, 31'h0, o_use_imm}, 64'h0);

    step(32'h104, 32'h0C12_FFFF, 1'b0, 1'b0, 1'b1);
    check("lit_sext", {o_imm32, 27'h0, o_sr2, o_use_imm}, {32'hFFFF_FFFF, 32'h1});
    step(32'h108, 32'h0D12_FFFF, 1'b0, 1'b0, 1'b1);
    check("lit_zext", 64'(o_imm32), 64'h0000_FFFF);
    step(32'h10C, 32'h0E12_FFFF, 1'b0, 1'b0, 1'b1);
    check("lit_hi", 64'(o_imm32), 64'hFFFF_0000);

    // Skid: SUB held by stall, LW lands in skid, MUL waits in prefetch
    step(32'h110, 32'h1045_6000, 1'b0, 1'b0, 1'b1);
    step(32'h114, 32'h4812_3000, 1'b1, 1'b0, 1'b1);
    check("lit_skid_stall", {o_pipe_stall, o_pc}, {1'b1, 32'h110});
    step(32'h118, 32'h1878_9000, 1'b1, 1'b0, 1'b1);
    check("lit_skid_hold", {o_pipe_stall, o_pc}, {1'b1, 32'h110});
    step(32'h118, 32'h1878_9000, 1'b0, 1'b0, 1'b1);
    check("lit_lw_out", {o_valid, o_is_load, o_pc}, {2'b11, 32'h114});
    check("lit_lw_unstall", 64'(o_pipe_stall), 64'h0);
    step(32'h118, 32'h1878_9000, 1'b0, 1'b0, 1'b1);
    check("lit_mul_out", {o_valid, o_opcode, o_pc}, {1'b1, 5'd3, 32'h118});
    step(32'h11C, 32'h0, 1'b0, 1'b0, 1'b1);
    check("lit_bubble", 64'(o_valid), 64'h0);

    // Illegal opcode
    step(32'h120, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    check("lit_illegal", {o_valid, o_illegal, o_opcode}, {2'b11, 5'd31});

    // Flush with skid full and input present
    step(32'h124, 32'h4812_3000, 1'b1, 1'b0, 1'b1);
    check("lit_fl_skid", 64'(o_pipe_stall), 64'h1);
    step(32'h128, 32'h5000_0000, 1'b1, 1'b1, 1'b1);
    check("lit_flush", {o_valid, o_pipe_stall}, 64'h0);
    step(32'h200, 32'h0812_3000, 1'b0, 1'b0, 1'b1);
    check("lit_post_flush", {o_valid, o_opcode, o_pc}, {1'b1, 5'd1, 32'h200});

    // Reset mid-stream with skid full and flush asserted
    step(32'h204, 32'h4812_3000, 1'b1, 1'b0, 1'b1);
    step(32'h208, 32'h0812_3000, 1'b1, 1'b1, 1'b0);
    check("lit_mid_reset", {o_valid, o_pipe_stall, o_pc, o_opcode, o_imm32[25:0]}, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("lit_bubble_hold", 64'(o_valid), 64'h0);
    end

    @(negedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
